// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter (and a future receiver).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Data bits per frame: code 0..3 means 5..8, clipped to what the datapath can hold.
  function automatic logic [3:0] bits_decode(input logic [1:0] code, input int unsigned max_bits);
    int unsigned n;
    n = 32'd5 + 32'(code);
    if (n > max_bits) n = max_bits;
    return 4'(n);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter: bit_end fires when the count reaches zero, then reloads the divisor.
module uart_baud_gen #(
  parameter int BAUD_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BAUD_W-1:0] divisor,
  input  logic              run,
  output logic              bit_end
);

  logic [BAUD_W-1:0] cnt_q;
  logic [BAUD_W-1:0] div_q;

  assign bit_end = run && (cnt_q == '0);

  // The divisor is captured at load so the period stays fixed for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      div_q <= '0;
    end else if (load) begin
      cnt_q <= divisor;
      div_q <= divisor;
    end else if (bit_end) begin
      cnt_q <= div_q;
    end else if (run) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter, LSB first, back-to-back frames with no idle gap.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
//   state  | meaning
//   IDLE   | line high, ready for a byte
//   START  | start bit (0)
//   DATA   | data bits from shift register bit 0
//   PARITY | parity bit (only with UART_TX_PARITY_EN)
//   STOP   | one or two stop bits (1)
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic [BAUD_W-1:0] cfg_baud,
  input  logic [1:0]        cfg_bits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              TX
);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q;
  logic [2:0]        bit_cnt_q;
  logic [3:0]        bits_q;
  logic              stop2_q;
  logic              stop_idx_q;
  logic              bit_end;
  logic              hs;
  logic              last_data;
  logic              last_stop;
`ifdef UART_TX_PARITY_EN
  logic              par_en_q;
  logic              par_odd_q;
  logic              par_acc_q;
`else
  logic              unused_parity;
  assign unused_parity = ^cfg_parity;
`endif

  uart_baud_gen #(.BAUD_W(BAUD_W)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (hs),
    .divisor (cfg_baud),
    .run     (state_q != IDLE),
    .bit_end (bit_end)
  );

  assign hs        = tx_valid && tx_ready;
  assign last_data = ({1'b0, bit_cnt_q} == (bits_q - 4'd1));
  assign last_stop = (stop_idx_q == stop2_q);
  assign tx_done   = (state_q == STOP) && bit_end && last_stop;
  assign tx_ready  = (state_q == IDLE) || tx_done;
  assign tx_busy   = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (hs) state_d = START;
      START:  if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end && last_data) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end && last_stop) state_d = hs ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    TX = 1'b1;
    unique case (state_q)
      START:  TX = 1'b0;
      DATA:   TX = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: TX = par_acc_q ^ par_odd_q;
`endif
      default: TX = 1'b1;
    endcase
  end

  // Frame-local copies: config is only honoured at the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '1;
      bit_cnt_q  <= '0;
      bits_q     <= '0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      par_acc_q  <= 1'b0;
`endif
    end else if (hs) begin
      shift_q    <= tx_data;
      bit_cnt_q  <= '0;
      bits_q     <= bits_decode(cfg_bits, DATA_W);
      stop2_q    <= cfg_stop2;
      stop_idx_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
      par_odd_q  <= (cfg_parity == PAR_ODD);
      par_acc_q  <= 1'b0;
`endif
    end else if (bit_end) begin
      if (state_q == DATA) begin
        shift_q   <= {1'b1, shift_q[DATA_W-1:1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        par_acc_q <= par_acc_q ^ shift_q[0];
`endif
      end
      if (state_q == STOP) stop_idx_q <= 1'b1;
    end
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Runtime-configurable UART transmitter, the next-generation serializer for the SPART path. It accepts bytes over a valid/ready handshake and serializes them LSB-first on `TX`. Per frame it supports 5–8 data bits, optional even/odd parity and 1 or 2 stop bits, with a programmable baud divisor. Back-to-back frames are sent with no idle gap. It sits between the SPART transmit queue and the pad.

## Interface
- `DATA_W`, default 8: maximum data bits per frame. Legal range 5–8.
- `BAUD_W`, default 13: width of the baud divisor.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `tx_valid` input 1: a byte is offered on `tx_data`.
- `tx_data` input `DATA_W`: payload. Bit 0 is sent first. Bits at and above `cfg_bits` are ignored.
- `tx_ready` output 1: the block will accept a byte this cycle.
- `cfg_baud` input `BAUD_W`: bit period is `cfg_baud+1` clk cycles.
- `cfg_bits` input 2: data bits per frame, coded as 0→5, 1→6, 2→7, 3→8. Codes above `DATA_W` saturate to `DATA_W`.
- `cfg_parity` input 2: `uart_pkg::parity_t`, one of NONE=0, EVEN=1, ODD=2. Value 3 is treated as NONE.
- `cfg_stop2` input 1: 1 selects two stop bits.
- `tx_busy` output 1: a frame is in progress (any state other than IDLE).
- `tx_done` output 1: one-cycle pulse in the final cycle of the last stop bit.
- `TX` output 1: serial line, idle high.

## Operation
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
- A handshake occurs when `tx_valid && tx_ready`. On it the block:
  - loads the shift register with `tx_data`;
  - latches `cfg_*` into frame-local registers;
  - loads the baud counter with `cfg_baud`;
  - clears the bit counter and the parity accumulator;
  - enters START.
- Config inputs are sampled only at the handshake. Changes mid-frame have no effect on the current frame.
- Baud counter: loads `cfg_baud` and decrements each cycle. The tick `bit_end` = (counter==0). Each tick reloads the counter and advances the FSM.
- `TX` levels by state:
  - START: 0.
  - DATA: shift-register bit 0. Each `bit_end` shifts right and increments the bit counter. The parity accumulator XORs in each sent bit.
  - PARITY: EVEN sends the accumulator; ODD sends its inverse.
  - STOP: 1, for 1 or 2 bit periods.
- DATA exits after the configured number of bits: to PARITY if parity is not NONE, otherwise to STOP.
- `tx_ready` is high in IDLE, and also in the final cycle of the last stop bit (`tx_done` cycle).
  - A handshake in that final stop cycle goes directly to START, so there are zero idle cycles between frames.
  - Otherwise the FSM returns to IDLE.
- `tx_data` is not required to be held after the handshake.
- All arithmetic is unsigned. The baud counter never underflows, because it reloads on `bit_end`.

## Timing
- Reset values: `TX`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0; FSM=IDLE; shift register all ones.
- Latency: `TX` falls on the clock edge that follows the handshake.
- Frame length in cycles = (1 + bits + P + S) × (`cfg_baud`+1), where P = 1 if parity is enabled (else 0) and S = the number of stop bits.
- `cfg_baud`=0 is legal and gives one cycle per bit.
- If `tx_valid` is asserted while `tx_ready`=0, there is no handshake. The offered data stays pending for the upstream block.
- Reset asserted mid-frame: `TX` returns high asynchronously and the frame is abandoned. No `tx_done` pulse is produced.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined: PARITY state, parity accumulator and `cfg_parity` decode are present, behaving as described above.
- Undefined: the PARITY state and accumulator are removed. `cfg_parity` remains a port but is ignored, and every frame is sent as no-parity.

## Structure
- `uart_pkg` holds:
  - `parity_t` enum;
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - `bits_decode()` function, mapping `cfg_bits` to a count with saturation at `DATA_W`.
- Sub-module `uart_baud_gen`:
  - inputs: `load`, `divisor`, `run`;
  - output: `bit_end`;
  - reusable by a future receiver.
- The FSM, shift register, bit counter and parity accumulator stay in `uart_tx_cfg`.

## Test plan
- 8N1, `cfg_baud`=3, `tx_data`=0xA5 → `TX` sequence 0,1,0,1,0,0,1,0,1,1. Each bit lasts 4 cycles. `tx_done` pulses at cycle 40 after the handshake edge.
- 8E1, `cfg_baud`=3, `tx_data`=0xA5 → the parity bit is 0 (four ones in the data). The frame is 11 bits (44 cycles).
- 7O2, `cfg_baud`=1, `tx_data`=0xD5 → data bits are 1,0,1,0,1,0,1 (bit 7 is ignored); the parity bit is 1; two stop bits follow. The frame is 11 bits (22 cycles).
- Back-to-back: `tx_valid` held high with 0x01 then 0x02 at 8N1, `cfg_baud`=0 → the second start bit immediately follows the first stop bit; `TX` is never idle between frames.
- Config change mid-frame: switch `cfg_stop2` from 0 to 1 during DATA → the current frame still ends with one stop bit; the next frame uses two.
- `rst_n` pulsed low during DATA → `TX`=1, `tx_busy`=0 and `tx_ready`=1 immediately. No `tx_done` pulse. The next handshake sends a complete, correct frame.
